// File: rtl/veda_burst_mem_if.sv
// Request / write-beat / read-beat bundle for veda_burst_mem.
//   master : drives req_*, mode, wr_data/wr_be/wr_valid, rd_ready
//   slave  : drives req_ready, wr_ready, rd_data/rd_valid/rd_last, busy
// Signals:
//   req_valid/req_ready  request handshake
//   req_write            1 = write burst, 0 = read burst
//   req_addr             start word address
//   req_len              beats minus one
//   mode                 0 = INCR, 1 = WRAP (sampled with the request)
//   wr_data/wr_be        write beat data and byte enables
//   wr_valid/wr_ready    write beat handshake
//   rd_data/rd_last      read beat data and final-beat marker
//   rd_valid/rd_ready    read beat handshake
//   busy                 burst in progress
interface veda_burst_mem_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int LEN_W  = 3
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [ADDR_W-1:0]     req_addr;
  logic [LEN_W-1:0]      req_len;
  logic                  mode;
  logic [DATA_W-1:0]     wr_data;
  logic [DATA_W/8-1:0]   wr_be;
  logic                  wr_valid;
  logic                  wr_ready;
  logic [DATA_W-1:0]     rd_data;
  logic                  rd_valid;
  logic                  rd_last;
  logic                  rd_ready;
  logic                  busy;

  modport master (
    output req_valid, req_write, req_addr, req_len, mode,
           wr_data, wr_be, wr_valid, rd_ready,
    input  req_ready, wr_ready, rd_data, rd_valid, rd_last, busy
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_len, mode,
           wr_data, wr_be, wr_valid, rd_ready,
    output req_ready, wr_ready, rd_data, rd_valid, rd_last, busy
  );
endinterface

// File: rtl/veda_burst_mem.sv
// veda_burst_mem: single-port synchronous RAM with a valid/ready request
// channel and multi-beat INCR/WRAP bursts, per-beat byte strobes on writes
// and back-pressured, registered read data.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-low reset (0 = in reset); RAM contents are
//          not cleared, an in-flight burst is abandoned
//   bus    veda_burst_mem_if slave modport (request, write beat, read beat,
//          busy)
module veda_burst_mem #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int LEN_W  = 3
) (
  input logic              clk,
  input logic              reset,
  veda_burst_mem_if.slave  bus
);
  localparam int BE_W  = DATA_W / 8;
  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [LEN_W:0] ONE_N = 1;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    READ
  } state_t;

  state_t              state;
  logic [ADDR_W-1:0]   addr_q;
  logic [LEN_W-1:0]    len_q;
  logic [LEN_W-1:0]    beat_q;
  logic                mode_q;

  logic                req_ready_q;
  logic                wr_ready_q;
  logic                rd_valid_q;
  logic                rd_last_q;
  logic [DATA_W-1:0]   rd_data_q;
  logic                busy_q;

  logic [DATA_W-1:0]   mem [DEPTH];

  // Next burst address. WRAP only applies when the beat count is a power
  // of two; the low bits inside the N-aligned block roll over while the
  // block base stays put. Any other count falls back to INCR.
  logic [LEN_W:0]      n_beats;
  logic                wrap_en;
  logic [ADDR_W-1:0]   wrap_mask;
  logic [ADDR_W-1:0]   addr_inc;
  logic [ADDR_W-1:0]   addr_next;

  always_comb begin
    n_beats   = {1'b0, len_q} + ONE_N;
    wrap_en   = mode_q && ((n_beats & {1'b0, len_q}) == '0);
    wrap_mask = ADDR_W'(len_q);
    addr_inc  = addr_q + ADDR_W'(1);
    addr_next = wrap_en ? ((addr_q & ~wrap_mask) | (addr_inc & wrap_mask))
                        : addr_inc;
  end

  logic beat_wr;
  logic rd_load;
  logic rd_done;

  // Output register refills when empty or when its beat is being taken,
  // but never once the last beat is sitting in it.
  always_comb begin
    beat_wr = (state == WRITE) && bus.wr_valid && wr_ready_q;
    rd_load = (state == READ) && (!rd_valid_q || (bus.rd_ready && !rd_last_q));
    rd_done = (state == READ) && rd_valid_q && bus.rd_ready && rd_last_q;
  end

  // Storage has no reset so contents survive it; wr_ready_q is cleared
  // asynchronously, which blocks any write while reset is held.
  always_ff @(posedge clk) begin
    if (beat_wr) begin
      for (int unsigned i = 0; i < BE_W; i++) begin
        if (bus.wr_be[i]) begin
          mem[addr_q][i*8 +: 8] <= bus.wr_data[i*8 +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      addr_q      <= '0;
      len_q       <= '0;
      beat_q      <= '0;
      mode_q      <= 1'b0;
      req_ready_q <= 1'b1;
      wr_ready_q  <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_last_q   <= 1'b0;
      rd_data_q   <= '0;
      busy_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid && req_ready_q) begin
            addr_q      <= bus.req_addr;
            len_q       <= bus.req_len;
            mode_q      <= bus.mode;
            beat_q      <= '0;
            req_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            if (bus.req_write) begin
              state      <= WRITE;
              wr_ready_q <= 1'b1;
            end else begin
              state <= READ;
            end
          end
        end

        WRITE: begin
          if (beat_wr) begin
            addr_q <= addr_next;
            beat_q <= beat_q + LEN_W'(1);
            if (beat_q == len_q) begin
              state       <= IDLE;
              wr_ready_q  <= 1'b0;
              req_ready_q <= 1'b1;
              busy_q      <= 1'b0;
            end
          end
        end

        READ: begin
          if (rd_load) begin
            rd_data_q  <= mem[addr_q];
            rd_last_q  <= (beat_q == len_q);
            rd_valid_q <= 1'b1;
            addr_q     <= addr_next;
            beat_q     <= beat_q + LEN_W'(1);
          end else if (rd_done) begin
            rd_valid_q  <= 1'b0;
            rd_last_q   <= 1'b0;
            state       <= IDLE;
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.wr_ready  = wr_ready_q;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.rd_last   = rd_last_q;
  assign bus.rd_data   = rd_data_q;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_veda_burst_mem.sv
// Self-checking bench for veda_burst_mem: directed scenarios followed by
// random bursts, all checked against an array model of the RAM and an
// arithmetic model of the burst address sequence.
module tb_veda_burst_mem;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int LEN_W  = 3;
  localparam int DEPTH  = 32;

  logic clk = 1'b0;
  logic reset;

  int vectors     = 0;
  int miscompares = 0;

  logic [31:0] ref_mem [DEPTH];
  logic [31:0] wdata [8];
  logic [3:0]  wbe [8];
  int          rd_pat [7] = '{1, 0, 0, 1, 1, 0, 1};

  veda_burst_mem_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) bus ();

  veda_burst_mem #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Address of beat k of a burst, straight from the burst rules.
  function automatic int beat_addr(input int start, input int len, input bit m, input int k);
    int n;
    int base;
    n = len + 1;
    if (m && (n == 1 || n == 2 || n == 4 || n == 8)) begin
      base = (start / n) * n;
      return base + ((start - base + k) % n);
    end
    return (start + k) % DEPTH;
  endfunction

  task automatic check_idle(input string tag);
    check({tag, "_req_ready"}, bus.req_ready, 1);
    check({tag, "_wr_ready"}, bus.wr_ready, 0);
    check({tag, "_rd_valid"}, bus.rd_valid, 0);
    check({tag, "_busy"}, bus.busy, 0);
  endtask

  task automatic check_reset_vals(input string tag);
    check_idle(tag);
    check({tag, "_rd_last"}, bus.rd_last, 0);
    check({tag, "_rd_data"}, bus.rd_data, 0);
  endtask

  // Returns #1 after the accepting edge; request fields are then scrambled
  // so any failure to latch them shows up.
  task automatic send_req(input bit w, input int a, input int len, input bit m);
    int n;
    @(negedge clk);
    bus.req_write = w;
    bus.req_addr  = 5'(a);
    bus.req_len   = 3'(len);
    bus.mode      = m;
    bus.req_valid = 1'b1;
    n = 0;
    while (!bus.req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("req_ready", bus.req_ready, 1);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.req_write = 1'($urandom);
    bus.req_addr  = 5'($urandom);
    bus.req_len   = 3'($urandom);
    bus.mode      = 1'($urandom);
  endtask

  // Sends `beats` beats of wdata/wbe (all of them when beats == len+1) and
  // returns at the negedge after the last beat sent.
  task automatic do_write(input int a, input int len, input bit m,
                          input bit stall_en, input int beats);
    int n;
    int ad;
    send_req(1'b1, a, len, m);
    @(negedge clk);
    check("wr_busy", bus.busy, 1);
    check("wr_req_ready_low", bus.req_ready, 0);
    for (int k = 0; k < beats; k++) begin
      if (stall_en) repeat ($urandom_range(0, 2)) @(negedge clk);
      bus.wr_valid = 1'b1;
      bus.wr_data  = wdata[k];
      bus.wr_be    = wbe[k];
      n = 0;
      while (!bus.wr_ready && n < 20) begin
        @(negedge clk);
        n++;
      end
      check("wr_ready", bus.wr_ready, 1);
      @(posedge clk);
      #1;
      bus.wr_valid = 1'b0;
      bus.wr_data  = $urandom;
      bus.wr_be    = 4'($urandom);
      ad = beat_addr(a, len, m, k);
      for (int i = 0; i < 4; i++) begin
        if (wbe[k][i]) ref_mem[ad][i*8 +: 8] = wdata[k][i*8 +: 8];
      end
      @(negedge clk);
    end
    if (beats == len + 1) check_idle("wr_end");
  endtask

  // bp: 0 = always ready, 1 = fixed toggle pattern, 2 = random ready
  task automatic do_read(input int a, input int len, input bit m, input int bp);
    logic [31:0] held_d;
    logic        held_l;
    bit          holding;
    bit          rdy;
    int          beat;
    int          cyc;
    int          pidx;
    send_req(1'b0, a, len, m);
    beat    = 0;
    cyc     = 0;
    pidx    = 0;
    holding = 1'b0;
    held_d  = '0;
    held_l  = 1'b0;
    while (beat <= len && cyc < 200) begin
      @(negedge clk);
      if (cyc == 0) begin
        check("rd_lat1_valid", bus.rd_valid, 0);
        check("rd_busy", bus.busy, 1);
      end
      if (cyc == 1) check("rd_lat2_valid", bus.rd_valid, 1);
      if (holding) begin
        check("rd_hold_valid", bus.rd_valid, 1);
        check("rd_hold_data", bus.rd_data, held_d);
        check("rd_hold_last", bus.rd_last, held_l);
      end
      if (bp == 0) rdy = 1'b1;
      else if (bp == 1) begin
        if (bus.rd_valid) begin
          rdy = rd_pat[pidx % 7] != 0;
          pidx++;
        end else rdy = 1'b1;
      end else rdy = 1'($urandom_range(0, 1));
      bus.rd_ready = rdy;
      if (bus.rd_valid) begin
        if (rdy) begin
          check("rd_data", bus.rd_data, ref_mem[beat_addr(a, len, m, beat)]);
          check("rd_last", bus.rd_last, (beat == len) ? 1 : 0);
          beat++;
          holding = 1'b0;
        end else begin
          holding = 1'b1;
          held_d  = bus.rd_data;
          held_l  = bus.rd_last;
        end
      end
      cyc++;
    end
    if (beat <= len) check("rd_timeout_beats", beat, len + 1);
    @(negedge clk);
    bus.rd_ready = 1'b0;
    check_idle("rd_end");
  endtask

  initial begin
    reset         = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_len   = '0;
    bus.mode      = 1'b0;
    bus.wr_data   = '0;
    bus.wr_be     = '0;
    bus.wr_valid  = 1'b0;
    bus.rd_ready  = 1'b0;

    #12;
    check_reset_vals("por");
    @(negedge clk);
    reset = 1'b1;

    // Give every word a known value.
    for (int b = 0; b < 4; b++) begin
      for (int k = 0; k < 8; k++) begin
        wdata[k] = $urandom;
        wbe[k]   = 4'hF;
      end
      do_write(b * 8, 7, 1'b0, 1'b0, 8);
    end

    // Single word.
    wdata[0] = 32'h12345678;
    wbe[0]   = 4'hF;
    do_write(5, 0, 1'b0, 1'b1, 1);
    do_read(5, 0, 1'b0, 0);

    // INCR burst across the top of the address space.
    for (int k = 0; k < 4; k++) begin
      wdata[k] = 32'hA0 + 32'(k);
      wbe[k]   = 4'hF;
    end
    do_write(30, 3, 1'b0, 1'b0, 4);
    do_read(30, 3, 1'b0, 0);

    // WRAP with a power-of-two count, then a non-power-of-two count.
    for (int k = 0; k < 8; k++) begin
      wdata[k] = 32'hC0DE_0000 + 32'($urandom_range(0, 255) * 8 + k);
      wbe[k]   = 4'hF;
    end
    do_write(8, 7, 1'b0, 1'b0, 8);
    do_read(13, 3, 1'b1, 0);
    do_read(13, 2, 1'b1, 0);

    // Byte enables.
    wdata[0] = 32'h12238897;
    wbe[0]   = 4'hF;
    do_write(7, 0, 1'b0, 1'b0, 1);
    wdata[0] = 32'hFFFFFFFF;
    wbe[0]   = 4'h5;
    do_write(7, 0, 1'b0, 1'b0, 1);
    do_read(7, 0, 1'b0, 0);

    // Back-pressure with the fixed toggle pattern.
    do_read(16, 3, 1'b0, 1);

    // Reset after two beats of a four-beat write.
    for (int k = 0; k < 4; k++) begin
      wdata[k] = 32'h5EED_0000 + 32'(k);
      wbe[k]   = 4'hF;
    end
    do_write(20, 3, 1'b0, 1'b0, 2);
    bus.wr_valid = 1'b1;
    bus.wr_data  = wdata[2];
    bus.wr_be    = 4'hF;
    reset        = 1'b0;
    #1;
    check_reset_vals("mid_rst");
    repeat (2) @(negedge clk);
    reset        = 1'b1;
    bus.wr_valid = 1'b0;
    @(negedge clk);
    check_idle("post_rst");
    do_read(20, 3, 1'b0, 0);

    // Random bursts.
    for (int t = 0; t < 40; t++) begin
      int a;
      int len;
      bit m;
      a   = $urandom_range(0, DEPTH - 1);
      len = $urandom_range(0, 7);
      m   = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) begin
        for (int k = 0; k < 8; k++) begin
          wdata[k] = $urandom;
          wbe[k]   = 4'($urandom_range(0, 15));
        end
        do_write(a, len, m, 1'b1, len + 1);
      end else begin
        do_read(a, len, m, 2);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
